// File: rtl/uart_tx_driver.sv
// uart_tx_driver
// Memory-mapped UART transmitter on the CPU IO bus. The CPU pushes bytes
// into a small TX FIFO through the data register. The transmitter sends
// them LSB first in 8N1 format on uart_tx. Software polls the status
// register before writing.
//
// Ports:
//   clk            single clock, shared with the CPU bus
//   rst            synchronous, active-high reset
//   io_en          IO access qualifier
//   io_we          write strobe, only meaningful when io_en is high
//   io_addr        IO offset (ADDR_DATA: write byte, ADDR_STAT: status)
//   io_write_data  write data; bits [7:0] carry the byte to send
//   io_read_data   status word {16'b0, count, 4'b0, ovf, empty, full, busy}.
//                  It is zero unless a status read is in progress, so the
//                  bus can OR this output with the other peripherals.
//   uart_tx        serial line, idle high
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between data bit 7 and the stop bit, which gives an 11-bit frame.
module uart_tx_driver #(
  parameter int          CLKS_PER_BIT = 217,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [11:0] ADDR_DATA    = 12'h100,
  parameter logic [11:0] ADDR_STAT    = 12'h104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [11:0] io_addr,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        uart_tx
);

  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_clr;
  logic w_rd;
  logic w_full;
  logic w_empty;
  logic w_busy;
  logic w_baud_done;
  logic w_tx;
  logic w_unused;

  // Bus decode
  assign w_push_req  = io_en & io_we & (io_addr == ADDR_DATA);
  assign w_clr       = io_en & io_we & (io_addr == ADDR_STAT);
  assign w_rd        = io_en & ~io_we & (io_addr == ADDR_STAT);
  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_busy      = (r_state != S_IDLE);
  assign w_baud_done = (r_baud == BAUD_LAST);
  // A pop in the same cycle frees one slot, so a push to a full FIFO is still taken.
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_unused    = &{1'b0, io_write_data[31:8]};

  // Next-state and line level
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_baud_done) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_baud_done && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_tx = r_par;
        if (w_baud_done) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_baud_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, baud timing, FIFO pointers and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // The state only changes when a bit period ends or when leaving IDLE,
      // so this also reloads the counter on every state change.
      if ((r_state == S_IDLE) || w_baud_done) r_baud <= '0;
      else                                     r_baud <= r_baud + 1'b1;

      if (w_pop)                                  r_bit_idx <= '0;
      else if ((r_state == S_DATA) && w_baud_done) r_bit_idx <= r_bit_idx + 1'b1;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      if (w_clr)                                r_ovf <= 1'b0;
      else if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // Datapath: FIFO storage and shift register (no reset needed)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= io_write_data[7:0];
    if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
      r_par   <= ^r_mem[r_rd_ptr];
`endif
    end else if ((r_state == S_DATA) && w_baud_done) begin
      r_shift <= r_shift >> 1;
    end
  end

  assign uart_tx      = w_tx;
  assign io_read_data = w_rd ? {16'b0, 8'(r_count), 4'b0, r_ovf, w_empty, w_full, w_busy}
                             : 32'h0;

endmodule
